// File: rtl/pulse_train_gen.sv
// Programmable pulse-train source: emits i_count registered pulses of i_high
// cycles separated by i_low-cycle gaps, then a one-cycle done strobe.
module pulse_train_gen #(
  parameter int N_BIT = 12,
  parameter int W_BIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [N_BIT-1:0] i_count,
  input  logic [W_BIT-1:0] i_high,
  input  logic [W_BIT-1:0] i_low,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_done,
  output logic [N_BIT-1:0] o_remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_pulse;
  logic             w_pulse_nx;
  logic             r_done;
  logic             w_done_nx;
  logic [N_BIT-1:0] r_remaining;
  logic [N_BIT-1:0] w_remaining_nx;
  logic [W_BIT-1:0] r_width;
  logic [W_BIT-1:0] w_width_nx;
  logic [W_BIT-1:0] r_high;
  logic [W_BIT-1:0] w_high_nx;
  logic [W_BIT-1:0] r_low;
  logic [W_BIT-1:0] w_low_nx;
  logic [W_BIT-1:0] w_high_len;
  logic [W_BIT-1:0] w_low_len;
  logic [W_BIT-1:0] w_start_len;

  // Width counter holds "cycles left minus one", so a zero width behaves as one cycle.
  assign w_high_len  = (r_high == '0) ? '0 : r_high - W_BIT'(1);
  assign w_low_len   = (r_low  == '0) ? '0 : r_low  - W_BIT'(1);
  assign w_start_len = (i_high == '0) ? '0 : i_high - W_BIT'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pulse     <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_width     <= '0;
      r_high      <= '0;
      r_low       <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_pulse     <= w_pulse_nx;
      r_done      <= w_done_nx;
      r_remaining <= w_remaining_nx;
      r_width     <= w_width_nx;
      r_high      <= w_high_nx;
      r_low       <= w_low_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_pulse_nx     = r_pulse;
    w_done_nx      = 1'b0;
    w_remaining_nx = r_remaining;
    w_width_nx     = r_width;
    w_high_nx      = r_high;
    w_low_nx       = r_low;

    case (r_state)
      S_IDLE: begin
        w_pulse_nx = 1'b0;
        if (i_start && !i_abort) begin
          w_high_nx = i_high;
          w_low_nx  = i_low;
          if (i_count == '0) begin
            w_state_nx     = S_DONE;
            w_done_nx      = 1'b1;
            w_remaining_nx = '0;
          end else begin
            w_state_nx     = S_HIGH;
            w_pulse_nx     = 1'b1;
            w_remaining_nx = i_count - N_BIT'(1);
            w_width_nx     = w_start_len;
          end
        end
      end
      S_HIGH: begin
        if (r_width == '0) begin
          w_pulse_nx = 1'b0;
          if (r_remaining == '0) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx = S_LOW;
            w_width_nx = w_low_len;
          end
        end else begin
          w_width_nx = r_width - W_BIT'(1);
        end
      end
      S_LOW: begin
        if (r_width == '0) begin
          w_state_nx     = S_HIGH;
          w_pulse_nx     = 1'b1;
          w_remaining_nx = r_remaining - N_BIT'(1);
          w_width_nx     = w_high_len;
        end else begin
          w_width_nx = r_width - W_BIT'(1);
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_pulse_nx = 1'b0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_pulse_nx = 1'b0;
      end
    endcase

    // Abort wins over everything once a train is in flight; it never produces a done strobe.
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nx     = S_IDLE;
      w_pulse_nx     = 1'b0;
      w_done_nx      = 1'b0;
      w_remaining_nx = '0;
      w_width_nx     = '0;
    end
  end

  assign o_pulse     = r_pulse;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_remaining = r_remaining;

endmodule
